// File: rtl/op_sched_pkg.sv
// Shared types and defaults for the image-core operation scheduler.
package op_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        WAIT,
        LOAD,
        START,
        EXEC
    } state_t;

    localparam int LOAD_BEATS = 2048;
    localparam int ADDR_W     = 11;
    localparam int MODE_W     = 4;
    localparam int TIMEOUT    = 4096;

    localparam logic [3:0] OP_LOAD = 4'd0;

endpackage

// File: rtl/op_sched_ctrl_beat_counter.sv
// Wrapping up-counter with synchronous clear, enable and a terminal-count flag.
module beat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         at_max
);

    assign at_max = (count == MAX);

    // Wraps back to zero on the enabled cycle that sits at MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_max ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/op_sched_ctrl.sv
// Operation scheduler: op handshake, ifmap load sequencing and datapath dispatch.
// Optional watchdog abort enabled by defining OP_TIMEOUT_EN.
module op_sched_ctrl #(
    parameter int LOAD_BEATS = op_sched_pkg::LOAD_BEATS,
    parameter int ADDR_W     = op_sched_pkg::ADDR_W,
    parameter int MODE_W     = op_sched_pkg::MODE_W,
    parameter int TIMEOUT    = op_sched_pkg::TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_op_valid,
    input  logic [MODE_W-1:0] i_op_mode,
    output logic              o_op_ready,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_load_we,
    output logic [ADDR_W-1:0] o_load_addr,
    output logic              o_eng_start,
    output logic [MODE_W-1:0] o_eng_mode,
    input  logic              i_eng_done,
    input  logic              i_eng_out_valid,
    output logic              o_out_valid,
    output logic              o_err
);

    import op_sched_pkg::*;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] beat_addr;
    logic              beat_last;
    logic              abort;

    // Held at zero while waiting so every load starts at address 0.
    beat_counter #(
        .W   (ADDR_W),
        .MAX (ADDR_W'(LOAD_BEATS - 1))
    ) u_load_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == WAIT),
        .enable (o_load_we),
        .count  (beat_addr),
        .at_max (beat_last)
    );

`ifdef OP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT);

    logic [WD_W-1:0] wd_count;
    logic            wd_at_max;
    logic            wd_run;

    // Counts every EXEC cycle and every LOAD stall cycle; cleared elsewhere.
    assign wd_run = (state == EXEC) || ((state == LOAD) && !i_in_valid);

    beat_counter #(
        .W   (WD_W),
        .MAX (WD_W'(TIMEOUT - 1))
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  ((state != EXEC) && (state != LOAD)),
        .enable (wd_run),
        .count  (wd_count),
        .at_max (wd_at_max)
    );

    assign abort = wd_run && wd_at_max && !((state == EXEC) && i_eng_done);
`else
    assign abort = 1'b0;
`endif

    assign o_err       = abort;
    assign o_load_we   = i_in_valid && o_in_ready;
    assign o_load_addr = beat_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_eng_mode <= '0;
        end else if ((state == WAIT) && i_op_valid) begin
            o_eng_mode <= i_op_mode;
        end
    end

    always_comb begin
        state_next  = state;
        o_op_ready  = 1'b0;
        o_in_ready  = 1'b0;
        o_eng_start = 1'b0;
        o_out_valid = 1'b0;
        case (state)
            IDLE: begin
                state_next = READY;
            end
            READY: begin
                o_op_ready = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (i_op_valid) begin
                    state_next = (i_op_mode == MODE_W'(OP_LOAD)) ? LOAD : START;
                end
            end
            LOAD: begin
                o_in_ready = 1'b1;
                if (abort || (i_in_valid && beat_last)) begin
                    state_next = READY;
                end
            end
            START: begin
                o_eng_start = 1'b1;
                state_next  = EXEC;
            end
            EXEC: begin
                // A result beat coinciding with done still goes out.
                o_out_valid = i_eng_out_valid && !abort;
                if (i_eng_done || abort) begin
                    state_next = READY;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_op_sched_ctrl.sv
// Directed, table-driven bench for op_sched_ctrl (watchdog case under OP_TIMEOUT_EN).
module tb_op_sched_ctrl;

    localparam int LOAD_BEATS = 2048;
    localparam int TMO        = 64;
`ifdef OP_TIMEOUT_EN
    localparam int BUBBLE_MAX = 0;
    localparam int EXEC_BEATS = 40;
`else
    localparam int BUBBLE_MAX = 4;
    localparam int EXEC_BEATS = 196;
`endif

    typedef struct {
        logic        op_valid;
        logic [3:0]  op_mode;
        logic        in_valid;
        logic        eng_done;
        logic        eng_out_valid;
        logic        e_op_ready;
        logic        e_in_ready;
        logic        e_load_we;
        logic [10:0] e_addr;
        logic        e_eng_start;
        logic        e_out_valid;
        logic [3:0]  e_mode;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_op_valid = 1'b0;
    logic [3:0]  i_op_mode = 4'd0;
    logic        o_op_ready;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic        o_load_we;
    logic [10:0] o_load_addr;
    logic        o_eng_start;
    logic [3:0]  o_eng_mode;
    logic        i_eng_done = 1'b0;
    logic        i_eng_out_valid = 1'b0;
    logic        o_out_valid;
    logic        o_err;

    int vectors = 0;
    int miscompares = 0;

    op_sched_ctrl #(
        .LOAD_BEATS (LOAD_BEATS),
        .ADDR_W     (11),
        .MODE_W     (4),
        .TIMEOUT    (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_op_valid      (i_op_valid),
        .i_op_mode       (i_op_mode),
        .o_op_ready      (o_op_ready),
        .i_in_valid      (i_in_valid),
        .o_in_ready      (o_in_ready),
        .o_load_we       (o_load_we),
        .o_load_addr     (o_load_addr),
        .o_eng_start     (o_eng_start),
        .o_eng_mode      (o_eng_mode),
        .i_eng_done      (i_eng_done),
        .i_eng_out_valid (i_eng_out_valid),
        .o_out_valid     (o_out_valid),
        .o_err           (o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] outputs_now();
        return {o_op_ready, o_in_ready, o_load_we, o_eng_start, o_out_valid, o_err,
                o_eng_mode, o_load_addr};
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge, returns at the falling edge.
    task automatic apply_stimulus(input logic ov, input logic [3:0] om, input logic iv,
                                  input logic dn, input logic eov);
        @(posedge clk);
        #1;
        i_op_valid      = ov;
        i_op_mode       = om;
        i_in_valid      = iv;
        i_eng_done      = dn;
        i_eng_out_valid = eov;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t tbl[13];

    initial begin
        int seen;
        int bad;
        int err_seen;
        int err_cycle;
        logic err_ov;
        logic [20:0] exp_vec;

        tbl[0]  = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 4'd5};
        tbl[4]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b1, 4'd5};
        tbl[5]  = '{1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 4'd5};
        tbl[6]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b1, 4'd5};
        tbl[7]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 4'd5};
        tbl[8]  = '{1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 4'd5};
        tbl[9]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd1, 1'b0, 1'b0, 4'd0};
        tbl[11] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd1, 1'b0, 1'b0, 4'd0};
        tbl[12] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd2, 1'b0, 1'b0, 4'd0};

        repeat (3) @(negedge clk);
        check_output("outputs_in_reset", 32'(outputs_now()), 32'd0);
        rst_n = 1'b1;
        #1;
        check_output("outputs_idle", 32'(outputs_now()), 32'd0);

        // Reset release, stray handshakes, a short exec op and the start of a load.
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(tbl[i].op_valid, tbl[i].op_mode, tbl[i].in_valid,
                           tbl[i].eng_done, tbl[i].eng_out_valid);
            exp_vec = {tbl[i].e_op_ready, tbl[i].e_in_ready, tbl[i].e_load_we,
                       tbl[i].e_eng_start, tbl[i].e_out_valid, 1'b0,
                       tbl[i].e_mode, tbl[i].e_addr};
            check_output($sformatf("table_row_%0d", i), 32'(outputs_now()), 32'(exp_vec));
        end

        for (int b = 2; b < LOAD_BEATS; b++) begin
            repeat ($urandom_range(0, BUBBLE_MAX)) idle_cycle();
            apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
            check_output($sformatf("load_beat_%0d", b),
                         32'({o_in_ready, o_load_we, o_load_addr}), 32'({1'b1, 1'b1, 11'(b)}));
        end
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check_output("after_last_beat", 32'({o_op_ready, o_in_ready, o_load_we}), 32'(3'b100));

        apply_stimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        check_output("exec_accept", 32'(outputs_now()), 32'd0);
        idle_cycle();
        check_output("exec_start", 32'({o_eng_start, o_eng_mode}), 32'({1'b1, 4'd5}));
        seen = 0;
        for (int k = 0; k < EXEC_BEATS; k++) begin
            repeat ($urandom_range(0, BUBBLE_MAX)) begin
                idle_cycle();
                if (o_out_valid) seen++;
            end
            apply_stimulus(1'b0, 4'd0, 1'b0, (k == EXEC_BEATS - 1), 1'b1);
            if (o_out_valid) seen++;
        end
        check_output("exec_out_count", 32'(seen), 32'(EXEC_BEATS));
        idle_cycle();
        check_output("ready_after_done", 32'({o_op_ready, o_out_valid, o_eng_start}), 32'(3'b100));

        apply_stimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        check_output("mode3_start", 32'({o_eng_start, o_eng_mode}), 32'({1'b1, 4'd3}));
`ifdef OP_TIMEOUT_EN
        err_cycle = 0;
        err_ov = 1'b1;
        for (int k = 1; k <= TMO + 4; k++) begin
            apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
            if (o_err) begin
                err_cycle = k;
                err_ov = o_out_valid;
                break;
            end
        end
        check_output("timeout_cycle", 32'(err_cycle), 32'(TMO));
        check_output("timeout_masked", 32'(err_ov), 32'd0);
        idle_cycle();
        check_output("ready_after_timeout", 32'({o_op_ready, o_err}), 32'(2'b10));
`else
        err_seen = 0;
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'(k % 2));
            if (o_err) err_seen++;
            if (o_out_valid !== 1'(k % 2)) bad++;
        end
        check_output("err_tied_low", 32'(err_seen), 32'd0);
        check_output("long_exec_passthru", 32'(bad), 32'd0);
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle_cycle();
        check_output("ready_after_long_exec", 32'({o_op_ready, o_err}), 32'(2'b10));
`endif

        // Abort a load part-way with reset; the next load must restart at 0.
        apply_stimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 1000; b++) begin
            repeat ($urandom_range(0, BUBBLE_MAX)) idle_cycle();
            apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        end
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check_output("beat_1000", 32'({o_in_ready, o_load_we, o_load_addr}), 32'({1'b1, 1'b1, 11'd1000}));
        rst_n = 1'b0;
        #1;
        check_output("reset_mid_load", 32'(outputs_now()), 32'd0);
        i_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        check_output("ready_after_reset", 32'(outputs_now()), 32'({1'b1, 20'd0}));
        apply_stimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check_output("reload_first_addr", 32'({o_in_ready, o_load_we, o_load_addr}), 32'({1'b1, 1'b1, 11'd0}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/op_sched_ctrl.md
Name: op_sched_ctrl

Overview:
- Top-level operation scheduler for the image-processing core.
- Owns the op_ready / op_valid command handshake and sequences the 2048-byte ifmap load into the feature SRAM.
- Dispatches every other op mode to the compute datapath with a start/done handshake and gates datapath output onto the core output port.
- Guarantees the core's mutual-exclusion rules (op_ready vs op_valid / in_valid / out_valid) by construction.

Parameters:
LOAD_BEATS, 2048, number of ifmap bytes accepted per load op (mode 0)
ADDR_W, 11, width of load address, equals clog2(LOAD_BEATS)
MODE_W, 4, op mode width
TIMEOUT, 4096, watchdog limit in cycles (used only with OP_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_op_valid  in  1  op command valid, single-cycle pulse
i_op_mode  in  MODE_W  op code, sampled when i_op_valid=1
o_op_ready  out  1  one-cycle pulse: controller can accept a new op
i_in_valid  in  1  ifmap byte valid
o_in_ready  out  1  high while in LOAD and beats remain
o_load_we  out  1  SRAM write enable = i_in_valid & o_in_ready
o_load_addr  out  ADDR_W  SRAM write address = beat counter
o_eng_start  out  1  one-cycle pulse to datapath
o_eng_mode  out  MODE_W  registered op mode, held stable through EXEC
i_eng_done  in  1  datapath finished the current op (pulse)
i_eng_out_valid  in  1  datapath result valid
o_out_valid  out  1  i_eng_out_valid gated by state==EXEC
o_err  out  1  watchdog abort pulse (tied 0 when feature is off)

Behaviour:
- Reset (async, any state, including mid-load or mid-exec):
  - state=IDLE; beat counter=0; o_eng_mode=0.
  - All outputs 0.
- IDLE → READY unconditionally on the first clock after rst_n deasserts.
- READY:
  - o_op_ready=1 for exactly this one cycle, then → WAIT.
- WAIT:
  - All handshake outputs 0; waits indefinitely for i_op_valid.
  - On i_op_valid: latch i_op_mode into o_eng_mode.
  - Mode 0 → LOAD with counter=0.
  - Any other mode → START.
  - Any i_op_valid seen outside WAIT is ignored.
- LOAD:
  - o_in_ready=1.
  - Each i_in_valid=1 cycle: o_load_we=1 with o_load_addr=counter, then counter++.
  - Bubbles (i_in_valid=0) hold the counter.
  - After the beat at address LOAD_BEATS-1: counter wraps to 0, o_in_ready drops on the next cycle, → READY.
  - Extra i_in_valid after the last beat: no write.
- START:
  - o_eng_start=1 for exactly one cycle, → EXEC.
- EXEC:
  - o_out_valid = i_eng_out_valid, combinational pass-through, zero latency.
  - On i_eng_done: → READY. A beat arriving with done in the same cycle is still passed.
  - i_eng_out_valid outside EXEC is masked to 0.
- Invariant: o_op_ready is asserted only in READY, so it is never high together with o_out_valid, o_in_ready, or an expected i_op_valid.
- Latency:
  - op accept → o_eng_start: 1 cycle.
  - eng_done → o_op_ready: 1 cycle.
  - last load beat → o_op_ready: 1 cycle.

Optional Feature:
- Macro: OP_TIMEOUT_EN.
- With it defined:
  - A watchdog counter clears on entry to EXEC and increments every EXEC cycle.
  - On reaching TIMEOUT without i_eng_done: o_err pulses 1 cycle, output is masked, → READY.
  - The counter also runs in LOAD, but only while i_in_valid=0 (stall guard), with the same abort behaviour.
- Without it: no counter is instantiated and o_err is tied 0.

Decomposition:
- Package op_sched_pkg:
  - state enum {IDLE, READY, WAIT, LOAD, START, EXEC}.
  - OP_LOAD=4'd0, LOAD_BEATS, ADDR_W.
- One sub-module, beat_counter: parameterised width, with clear, enable, and terminal-count flag. Used for load addressing and for the watchdog.

Test Plan:
- Reset release → o_op_ready high exactly 1 cycle at cycle 1; all other outputs 0.
- Mode 0 with 2048 beats and random 0-4-cycle bubbles → addresses 0..2047 each written once; o_in_ready low after the 2048th beat; o_op_ready pulses 1 cycle later.
- Mode 5 → o_eng_start 1 cycle after op accept with o_eng_mode=5. Datapath sends 196 out beats then done → o_out_valid count=196; o_op_ready 1 cycle after done.
- i_eng_out_valid=1 while in WAIT, and a stray i_op_valid during EXEC → o_out_valid stays 0; mode unchanged.
- rst_n asserted mid-load at beat 1000 → outputs 0 immediately. The subsequent load starts again at address 0.
- With OP_TIMEOUT_EN and TIMEOUT=64, mode 3 with done never sent → o_err pulses at EXEC cycle 64, then o_op_ready on the next cycle.
